// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 frame constants, controller state encoding and parity helper
package ps2_pkg;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS   = 11;
    // host-to-device frame: 8 data + parity + stop falls
    localparam int TX_END_COUNT = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECEIVE,
        ST_TX_INHIBIT,
        ST_TX_REQUEST,
        ST_TRANSMIT,
        ST_ACK_WAIT
    } ps2_ctrl_state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - 2-flop synchronizer with optional glitch filter (PS2_GLITCH_FILTER_EN)
//
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   din        raw asynchronous pin level
//   dout       synchronized (and, when enabled, filtered) level; resets to 1
// The filter is built only when PS2_GLITCH_FILTER_EN is defined and use_filter=1;
// dout then follows the synchronized level only after filt_len consecutive
// samples that disagree with it.
module ps2_sync_filter #(
    parameter int unsigned filt_len   = 8,
    parameter bit          use_filter = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic s1;
    logic s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

`ifdef PS2_GLITCH_FILTER_EN
    if (use_filter) begin : g_filter
        localparam int CW = (filt_len > 1) ? $clog2(filt_len) : 1;
        localparam logic [CW-1:0] LAST = CW'(filt_len - 1);

        logic [CW-1:0] run_cnt;
        logic          filt_q;

        // run_cnt counts consecutive samples differing from the filtered level
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                run_cnt <= '0;
                filt_q  <= 1'b1;
            end else if (s2 == filt_q) begin
                run_cnt <= '0;
            end else if (run_cnt == LAST) begin
                filt_q  <= s2;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end

        assign dout = filt_q;
    end else begin : g_plain
        assign dout = s2;
    end
`else
    assign dout = s2;
`endif

endmodule

// File: rtl/ps2_shifter.sv
// rtl/ps2_shifter.sv - PS/2 receive/transmit bit shifter with status flags and timeout
//
// Ports:
//   sys_clk, sys_rst             clock, asynchronous active-high reset
//   ps2_clk_in, ps2_data_in      raw PS/2 pin levels
//   state_receive/state_transmit controller state qualifiers
//   tx_load, tx_data             byte load strobe and byte to send
//   rx_ack                       consumer has read rx_data
//   rx_bitcount                  bits counted in current frame
//   ps2_clk_2                    synchronized PS/2 clock
//   ps2_data_out2                transmit bit (1 = release)
//   rx_data, rx_avail            received byte and its valid flag
//   parity_err, frame_err, overrun, ack_err  sticky status
// Optional: PS2_GLITCH_FILTER_EN enables the clock glitch filter (filt_len samples).
module ps2_shifter
    import ps2_pkg::*;
#(
    parameter int unsigned clk_freq = 50000000,
    parameter int unsigned filt_len = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    input  logic       state_receive,
    input  logic       state_transmit,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    input  logic       rx_ack,
    output logic [4:0] rx_bitcount,
    output logic       ps2_clk_2,
    output logic       ps2_data_out2,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       ack_err
);

    localparam int unsigned TIMEOUT = clk_freq / 10000;
    localparam int          TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);

    logic                  data_sync;
    logic                  clk_prev;
    logic                  fall;
    logic                  active;
    logic                  rx_done;
    logic                  new_parity_err;
    logic                  new_frame_err;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] shift_next;
    logic [7:0]            tx_reg;
    logic                  tx_par;
    logic                  tx_bit;
    logic                  tx_next_bit;
    logic                  ack_pending;
    logic [TW-1:0]         tmo;

    ps2_sync_filter #(.filt_len(filt_len), .use_filter(1'b1)) u_clk_sync (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .din  (ps2_clk_in),
        .dout (ps2_clk_2)
    );

    ps2_sync_filter #(.filt_len(filt_len), .use_filter(1'b0)) u_data_sync (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .din  (ps2_data_in),
        .dout (data_sync)
    );

    assign fall           = clk_prev & ~ps2_clk_2;
    assign active         = (rx_bitcount != 5'd0) | ack_pending;
    // bits arrive LSB first: shift right, newest bit enters at the top
    assign shift_next     = {data_sync, shift_reg[FRAME_BITS-1:1]};
    assign rx_done        = (rx_bitcount == 5'(FRAME_BITS - 1));
    assign new_parity_err = ~(^shift_next[9:1]);
    assign new_frame_err  = shift_next[0] | ~shift_next[FRAME_BITS-1];
    assign ps2_data_out2  = tx_bit | ~state_transmit;

    // bit presented on the fall that moves the count from rx_bitcount to rx_bitcount+1
    always_comb begin
        tx_next_bit = 1'b1;
        if (rx_bitcount < 5'd8) begin
            tx_next_bit = tx_reg[rx_bitcount[2:0]];
        end else if (rx_bitcount == 5'd8) begin
            tx_next_bit = tx_par;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            clk_prev    <= 1'b1;
            rx_bitcount <= 5'd0;
            shift_reg   <= '0;
            rx_data     <= 8'h00;
            rx_avail    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            ack_err     <= 1'b0;
            ack_pending <= 1'b0;
            tx_reg      <= 8'h00;
            tx_par      <= 1'b0;
            tx_bit      <= 1'b1;
            tmo         <= TMO_LOAD;
        end else begin
            clk_prev <= ps2_clk_2;

            if (rx_ack) begin
                rx_avail   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
            end

            if (tx_load) begin
                tx_reg  <= tx_data;
                tx_par  <= odd_parity(tx_data);
                ack_err <= 1'b0;
            end

            if (!state_transmit) begin
                tx_bit <= 1'b1;
            end

            if (fall || !active) begin
                tmo <= TMO_LOAD;
            end else if (tmo != '0) begin
                tmo <= tmo - 1'b1;
            end

            if (fall) begin
                if (ack_pending && !state_transmit) begin
                    // device ack bit: sampled but not counted
                    ack_err     <= data_sync;
                    ack_pending <= 1'b0;
                    rx_bitcount <= 5'd0;
                end else if (state_transmit) begin
                    if (rx_bitcount < 5'(TX_END_COUNT)) begin
                        rx_bitcount <= rx_bitcount + 5'd1;
                        tx_bit      <= tx_next_bit;
                        if (rx_bitcount == 5'(TX_END_COUNT - 1)) begin
                            ack_pending <= 1'b1;
                        end
                    end
                end else if (state_receive) begin
                    shift_reg <= shift_next;
                    if (rx_done) begin
                        // completion overrides a same-cycle rx_ack clear
                        rx_bitcount <= 5'd0;
                        rx_data     <= shift_next[8:1];
                        rx_avail    <= 1'b1;
                        if (rx_ack) begin
                            parity_err <= new_parity_err;
                            frame_err  <= new_frame_err;
                            overrun    <= 1'b0;
                        end else begin
                            parity_err <= parity_err | new_parity_err;
                            frame_err  <= frame_err | new_frame_err;
                            overrun    <= overrun | rx_avail;
                        end
                    end else begin
                        rx_bitcount <= rx_bitcount + 5'd1;
                    end
                end
            end else if (active && tmo == '0) begin
                rx_bitcount <= 5'd0;
                ack_pending <= 1'b0;
                shift_reg   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_shifter.sv
// tb/tb_ps2_shifter.sv - directed self-checking bench for ps2_shifter
module tb_ps2_shifter;

    localparam int unsigned CLK_FREQ = 1000000;  // 100-cycle timeout
    localparam int unsigned FILT_LEN = 4;
    localparam int HALF = 40;                     // PS/2 half period in sys cycles
`ifdef PS2_GLITCH_FILTER_EN
    localparam int LAT = 2 + FILT_LEN;
`else
    localparam int LAT = 2;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       state_receive;
    logic       state_transmit;
    logic       tx_load;
    logic [7:0] tx_data;
    logic       rx_ack;
    logic [4:0] rx_bitcount;
    logic       ps2_clk_2;
    logic       ps2_data_out2;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       ack_err;

    int checks   = 0;
    int failures = 0;

    logic [4:0]  mid_cnt;
    logic        mid_out;
    logic [9:0]  exp_seq;
    logic [10:0] fr;

    ps2_shifter #(.clk_freq(CLK_FREQ), .filt_len(FILT_LEN)) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .ps2_clk_in     (ps2_clk_in),
        .ps2_data_in    (ps2_data_in),
        .state_receive  (state_receive),
        .state_transmit (state_transmit),
        .tx_load        (tx_load),
        .tx_data        (tx_data),
        .rx_ack         (rx_ack),
        .rx_bitcount    (rx_bitcount),
        .ps2_clk_2      (ps2_clk_2),
        .ps2_data_out2  (ps2_data_out2),
        .rx_data        (rx_data),
        .rx_avail       (rx_avail),
        .parity_err     (parity_err),
        .frame_err      (frame_err),
        .overrun        (overrun),
        .ack_err        (ack_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // one PS/2 clock pulse with data b; optional rx_ack on the cycle the fall is acted on
    task automatic ps2_bit(input logic b, input logic ack_it);
        ps2_data_in = b;
        cyc(HALF / 2);
        ps2_clk_in = 1'b0;
        if (ack_it) begin
            cyc(LAT);
            rx_ack = 1'b1;
            cyc(1);
            rx_ack = 1'b0;
            cyc(HALF - LAT - 1);
        end else begin
            cyc(HALF);
        end
        mid_cnt = rx_bitcount;
        mid_out = ps2_data_out2;
        ps2_clk_in = 1'b1;
        cyc(HALF / 2);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic par_flip, input logic stop);
        return {stop, (~(^d)) ^ par_flip, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int lo, input int hi, input logic ack_last);
        for (int i = lo; i <= hi; i++) begin
            ps2_bit(f[i], ack_last && (i == hi));
        end
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        cyc(1);
        rx_ack = 1'b0;
        cyc(2);
    endtask

    task automatic load_tx(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
        cyc(1);
    endtask

    initial begin
        sys_rst = 1'b1;
        ps2_clk_in = 1'b1;
        ps2_data_in = 1'b1;
        state_receive = 1'b0;
        state_transmit = 1'b0;
        tx_load = 1'b0;
        tx_data = 8'h00;
        rx_ack = 1'b0;
        cyc(3);

        check("rst_count", rx_bitcount, 0);
        check("rst_clk2", ps2_clk_2, 1);
        check("rst_dout", ps2_data_out2, 1);
        check("rst_rxdata", rx_data, 0);
        check("rst_avail", rx_avail, 0);
        check("rst_flags", {parity_err, frame_err, overrun, ack_err}, 0);

        sys_rst = 1'b0;
        cyc(5);
        state_receive = 1'b1;

        // good frame 0x1C
        send_bits(mk(8'h1C, 1'b0, 1'b1), 0, 10, 1'b0);
        cyc(5);
        check("rx1c_data", rx_data, 8'h1C);
        check("rx1c_avail", rx_avail, 1);
        check("rx1c_flags", {parity_err, frame_err, overrun}, 0);
        check("rx1c_count", rx_bitcount, 0);
        ack_pulse();
        check("ack_clear_avail", rx_avail, 0);

        // parity bit forced to 1
        send_bits(mk(8'h1C, 1'b1, 1'b1), 0, 10, 1'b0);
        cyc(5);
        check("par_err", parity_err, 1);
        check("par_frame", frame_err, 0);
        ack_pulse();
        check("par_cleared", parity_err, 0);

        // stop bit 0
        send_bits(mk(8'h33, 1'b0, 1'b0), 0, 10, 1'b0);
        cyc(5);
        check("frm_err", frame_err, 1);
        check("frm_par", parity_err, 0);
        ack_pulse();
        check("frm_cleared", frame_err, 0);

        // overrun: two frames without ack
        send_bits(mk(8'h11, 1'b0, 1'b1), 0, 10, 1'b0);
        send_bits(mk(8'h22, 1'b0, 1'b1), 0, 10, 1'b0);
        cyc(5);
        check("ovr_flag", overrun, 1);
        check("ovr_data", rx_data, 8'h22);
        // ack coincides with completion of the next frame
        send_bits(mk(8'h44, 1'b0, 1'b1), 0, 10, 1'b1);
        cyc(2);
        check("ackwin_avail", rx_avail, 1);
        check("ackwin_ovr", overrun, 0);
        check("ackwin_data", rx_data, 8'h44);
        ack_pulse();

        // falls in handshake states are ignored
        fr = mk(8'h55, 1'b0, 1'b1);
        send_bits(fr, 0, 2, 1'b0);
        check("hs_before", rx_bitcount, 3);
        state_receive = 1'b0;
        ps2_bit(1'b1, 1'b0);
        check("hs_hold", rx_bitcount, 3);
        state_receive = 1'b1;
        send_bits(fr, 3, 10, 1'b0);
        cyc(5);
        check("hs_data", rx_data, 8'h55);
        check("hs_flags", {parity_err, frame_err, overrun}, 0);
        ack_pulse();

        // timeout after 5 bits
        send_bits(mk(8'hA5, 1'b0, 1'b1), 0, 4, 1'b0);
        cyc(20);
        check("tmo_pending", rx_bitcount, 5);
        cyc(60);
        check("tmo_expired", rx_bitcount, 0);
        send_bits(mk(8'h5A, 1'b0, 1'b1), 0, 10, 1'b0);
        cyc(5);
        check("tmo_next_data", rx_data, 8'h5A);
        check("tmo_next_flags", {parity_err, frame_err, overrun}, 0);
        ack_pulse();

        // transmit 0xED: d0..d7 = 1,0,1,1,0,1,1,1 then parity 1, stop 1
        state_receive = 1'b0;
        load_tx(8'hED);
        state_transmit = 1'b1;
        exp_seq = 10'b11_1110_1101;
        for (int k = 0; k < 10; k++) begin
            ps2_bit(1'b1, 1'b0);
            check($sformatf("tx_bit%0d", k), mid_out, exp_seq[k]);
        end
        check("tx_count10", mid_cnt, 10);
        state_transmit = 1'b0;
        #1;
        check("tx_release", ps2_data_out2, 1);
        ps2_bit(1'b0, 1'b0);
        check("tx_ack0_err", ack_err, 0);
        check("tx_ack0_count", rx_bitcount, 0);

        // transmit 0x0F with device ack 1
        load_tx(8'h0F);
        state_transmit = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ps2_bit(1'b1, 1'b0);
        end
        check("tx2_count10", mid_cnt, 10);
        check("tx2_stop", mid_out, 1);
        state_transmit = 1'b0;
        ps2_bit(1'b1, 1'b0);
        check("tx_ack1_err", ack_err, 1);
        check("tx_ack1_count", rx_bitcount, 0);
        load_tx(8'h00);
        check("ackerr_cleared", ack_err, 0);

`ifdef PS2_GLITCH_FILTER_EN
        // short low glitch on the clock pin must not count
        state_receive = 1'b1;
        fr = mk(8'h3C, 1'b0, 1'b1);
        send_bits(fr, 0, 1, 1'b0);
        ps2_clk_in = 1'b0;
        cyc(3);
        ps2_clk_in = 1'b1;
        cyc(20);
        check("glitch_count", rx_bitcount, 2);
        send_bits(fr, 2, 10, 1'b0);
        cyc(5);
        check("glitch_data", rx_data, 8'h3C);
        ack_pulse();
`endif

        // reset in the middle of a frame
        state_receive = 1'b1;
        send_bits(mk(8'h66, 1'b0, 1'b1), 0, 10, 1'b0);
        send_bits(mk(8'h99, 1'b0, 1'b1), 0, 3, 1'b0);
        sys_rst = 1'b1;
        #1;
        check("mid_rst_count", rx_bitcount, 0);
        check("mid_rst_avail", rx_avail, 0);
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_clk2", ps2_clk_2, 1);
        check("mid_rst_flags", {parity_err, frame_err, overrun, ack_err}, 0);
        cyc(3);
        sys_rst = 1'b0;
        cyc(5);
        send_bits(mk(8'h99, 1'b0, 1'b1), 0, 10, 1'b0);
        cyc(5);
        check("post_rst_data", rx_data, 8'h99);
        check("post_rst_avail", rx_avail, 1);
        check("post_rst_flags", {parity_err, frame_err, overrun}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
